// File: rtl/uart_io_bridge.sv
// CPU IO-port to UART (8N1, LSB first) bridge with independent TX and RX byte FIFOs.
// The cpu handshakes only ever stall on a full TX FIFO or an empty RX FIFO.

module uart_io_fifo #(
   parameter int DATA_W    = 8,
   parameter int FIFO_LOG2 = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              not_empty
);
   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam logic [FIFO_LOG2:0] CNT_FULL = (FIFO_LOG2+1)'(DEPTH);

   logic [DATA_W-1:0]    mem [DEPTH];
   logic [FIFO_LOG2-1:0] wr_ptr;
   logic [FIFO_LOG2-1:0] rd_ptr;
   logic [FIFO_LOG2:0]   cnt;
   logic                 do_push;
   logic                 do_pop;

   // Flags come straight from the count register, so vld never feeds rdy.
   assign full      = (cnt == CNT_FULL);
   assign not_empty = (cnt != '0);
   assign do_pop    = pop && not_empty;
   assign do_push   = push && (!full || do_pop);
   assign head      = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      cnt <= cnt + 1'b1;
         else if (do_pop && !do_push) cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

module uart_io_bridge #(
   parameter int CLK_PER_BIT = 868,
   parameter int FIFO_LOG2   = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] io_out_data,
   input  logic       io_out_vld,
   output logic       io_out_rdy,
   output logic [7:0] io_in_data,
   output logic       io_in_vld,
   input  logic       io_in_rdy,
   output logic [4:0] io_err,
   input  logic       uart_rx,
   output logic       uart_tx
);
   localparam int CW = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   logic [7:0] tx_head, rx_head;
   logic       tx_full, tx_ne, tx_pop;
   logic       rx_full, rx_ne, rx_push;

   uart_io_fifo #(.DATA_W(8), .FIFO_LOG2(FIFO_LOG2)) u_tx_fifo (
      .clk(clk), .rstn(rstn), .push(io_out_vld), .push_data(io_out_data),
      .pop(tx_pop), .head(tx_head), .full(tx_full), .not_empty(tx_ne)
   );

   assign io_out_rdy = !tx_full;

   uart_state_t tx_state, tx_state_nxt;
   logic [CW-1:0] tx_cnt, tx_cnt_nxt;
   logic [2:0]    tx_idx, tx_idx_nxt;
   logic [7:0]    tx_shift, tx_shift_nxt;
   logic          tx_line_nxt;
   logic          tx_bit_end;

   assign tx_bit_end = (tx_cnt == BIT_LAST);

   always_comb begin
      tx_state_nxt = tx_state;
      tx_cnt_nxt   = tx_cnt;
      tx_idx_nxt   = tx_idx;
      tx_shift_nxt = tx_shift;
      tx_line_nxt  = uart_tx;
      tx_pop       = 1'b0;
      if (tx_state != IDLE) tx_cnt_nxt = tx_bit_end ? '0 : tx_cnt + 1'b1;
      case (tx_state)
         IDLE: begin
            if (tx_ne) begin
               tx_pop       = 1'b1;
               tx_shift_nxt = tx_head;
               tx_line_nxt  = 1'b0;
               tx_cnt_nxt   = '0;
               tx_state_nxt = START;
            end
         end
         START: begin
            if (tx_bit_end) begin
               tx_idx_nxt   = 3'd0;
               tx_line_nxt  = tx_shift[0];
               tx_state_nxt = DATA;
            end
         end
         DATA: begin
            if (tx_bit_end) begin
               if (tx_idx == 3'd7) begin
                  tx_line_nxt  = 1'b1;
                  tx_state_nxt = STOP;
               end else begin
                  tx_idx_nxt  = tx_idx + 3'd1;
                  tx_line_nxt = tx_shift[tx_idx + 3'd1];
               end
            end
         end
         STOP: begin
            // Chain straight into the next start bit when more bytes are waiting.
            if (tx_bit_end) begin
               if (tx_ne) begin
                  tx_pop       = 1'b1;
                  tx_shift_nxt = tx_head;
                  tx_line_nxt  = 1'b0;
                  tx_state_nxt = START;
               end else begin
                  tx_state_nxt = IDLE;
               end
            end
         end
         default: tx_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         tx_state <= IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         uart_tx  <= 1'b1;
      end else begin
         tx_state <= tx_state_nxt;
         tx_cnt   <= tx_cnt_nxt;
         tx_idx   <= tx_idx_nxt;
         uart_tx  <= tx_line_nxt;
      end
   end

   always_ff @(posedge clk) tx_shift <= tx_shift_nxt;

   uart_state_t rx_state, rx_state_nxt;
   logic [CW-1:0] rx_cnt, rx_cnt_nxt;
   logic [2:0]    rx_idx, rx_idx_nxt;
   logic [7:0]    rx_shift, rx_shift_nxt;
   logic          rx_meta, rx_sync, rx_prev;
   logic          rx_fall, rx_ferr_set, rx_ovf_set;
   logic          ferr, ovf;

   assign rx_fall = rx_prev && !rx_sync;

   always_comb begin
      rx_state_nxt = rx_state;
      rx_cnt_nxt   = rx_cnt;
      rx_idx_nxt   = rx_idx;
      rx_shift_nxt = rx_shift;
      rx_push      = 1'b0;
      rx_ferr_set  = 1'b0;
      case (rx_state)
         IDLE: begin
            if (rx_fall) begin
               rx_cnt_nxt   = '0;
               rx_state_nxt = START;
            end
         end
         START: begin
            // Mid-start-bit check; a high line here was only a glitch.
            if (rx_cnt == HALF_LAST) begin
               rx_cnt_nxt   = '0;
               rx_idx_nxt   = 3'd0;
               rx_state_nxt = rx_sync ? IDLE : DATA;
            end else begin
               rx_cnt_nxt = rx_cnt + 1'b1;
            end
         end
         DATA: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_nxt   = '0;
               rx_shift_nxt = {rx_sync, rx_shift[7:1]};
               rx_idx_nxt   = rx_idx + 3'd1;
               if (rx_idx == 3'd7) rx_state_nxt = STOP;
            end else begin
               rx_cnt_nxt = rx_cnt + 1'b1;
            end
         end
         STOP: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_nxt   = '0;
               rx_push      = rx_sync;
               rx_ferr_set  = !rx_sync;
               rx_state_nxt = IDLE;
            end else begin
               rx_cnt_nxt = rx_cnt + 1'b1;
            end
         end
         default: rx_state_nxt = IDLE;
      endcase
   end

   assign rx_ovf_set = rx_push && rx_full && !(io_in_rdy && rx_ne);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rx_state <= IDLE;
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         ferr     <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         rx_state <= rx_state_nxt;
         rx_cnt   <= rx_cnt_nxt;
         rx_idx   <= rx_idx_nxt;
         rx_meta  <= uart_rx;
         rx_sync  <= rx_meta;
         rx_prev  <= rx_sync;
         if (rx_ferr_set) ferr <= 1'b1;
         if (rx_ovf_set)  ovf  <= 1'b1;
      end
   end

   always_ff @(posedge clk) rx_shift <= rx_shift_nxt;

   uart_io_fifo #(.DATA_W(8), .FIFO_LOG2(FIFO_LOG2)) u_rx_fifo (
      .clk(clk), .rstn(rstn), .push(rx_push), .push_data(rx_shift_nxt),
      .pop(io_in_rdy), .head(rx_head), .full(rx_full), .not_empty(rx_ne)
   );

   assign io_in_vld  = rx_ne;
   assign io_in_data = rx_ne ? rx_head : 8'h00;
   assign io_err     = {3'b000, ferr, ovf};
endmodule

// File: tb/tb_uart_io_bridge.sv
// Self-checking bench for uart_io_bridge at CLK_PER_BIT=4, FIFO_LOG2=2.
// A serial monitor decodes uart_tx against a byte queue; RX bytes are checked as the cpu pops them.

module tb_uart_io_bridge;
   localparam int CPB = 4;
   localparam int FL2 = 2;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] io_out_data = 8'h00;
   logic       io_out_vld = 1'b0;
   logic       io_out_rdy;
   logic [7:0] io_in_data;
   logic       io_in_vld;
   logic       io_in_rdy = 1'b0;
   logic [4:0] io_err;
   logic       uart_rx = 1'b1;
   logic       uart_tx;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   logic [7:0] tx_exp[$];
   logic [7:0] rx_exp[$];
   int tx_start[$];

   typedef struct {
      logic [7:0] data;
      logic       stopb;
      logic       exp_vld;
      logic [4:0] exp_err;
   } rx_vec_t;
   rx_vec_t vecs[5];

   uart_io_bridge #(.CLK_PER_BIT(CPB), .FIFO_LOG2(FL2)) dut (
      .clk(clk), .rstn(rstn),
      .io_out_data(io_out_data), .io_out_vld(io_out_vld), .io_out_rdy(io_out_rdy),
      .io_in_data(io_in_data), .io_in_vld(io_in_vld), .io_in_rdy(io_in_rdy),
      .io_err(io_err), .uart_rx(uart_rx), .uart_tx(uart_tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Serial monitor: one sample per bit cell, abandoned if reset hits mid-frame.
   initial begin : tx_mon
      logic [7:0] b;
      logic       ok;
      logic       stopb;
      int         st;
      forever begin
         @(negedge clk);
         if (rstn && uart_tx == 1'b0) begin
            st = cyc;
            ok = 1'b1;
            b = 8'h00;
            stopb = 1'b0;
            for (int k = 1; k < 40 && ok; k++) begin
               @(negedge clk);
               if (!rstn) ok = 1'b0;
               else if (k % 4 == 0 && k <= 32) b[3'(k / 4 - 1)] = uart_tx;
               else if (k == 36) stopb = uart_tx;
            end
            if (ok) begin
               tx_start.push_back(st);
               check("tx_stop_bit", {31'b0, stopb}, 32'd1);
               if (tx_exp.size() == 0) begin
                  n_chk++;
                  $display("FAIL tx_unexpected: got frame 0x%0h, expected no frame", b);
               end else begin
                  check("tx_byte", {24'b0, b}, {24'b0, tx_exp.pop_front()});
               end
            end
         end
      end
   end

   task automatic cpu_write(input logic [7:0] b);
      int guard = 0;
      io_out_data = b;
      io_out_vld = 1'b1;
      @(negedge clk);
      while (!io_out_rdy && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (!io_out_rdy) begin
         n_chk++;
         $display("FAIL cpu_write_timeout: io_out_rdy=0 for byte 0x%0h, expected 1", b);
      end else begin
         tx_exp.push_back(b);
      end
      @(posedge clk);
      #1;
      io_out_vld = 1'b0;
   endtask

   task automatic cpu_read(input string name, input int limit);
      int guard = 0;
      @(negedge clk);
      while (!io_in_vld && guard < limit) begin
         @(negedge clk);
         guard++;
      end
      if (!io_in_vld) begin
         n_chk++;
         $display("FAIL %s_timeout: io_in_vld=0, expected 1", name);
      end else if (rx_exp.size() == 0) begin
         n_chk++;
         $display("FAIL %s_unexpected: got 0x%0h, expected no byte", name, io_in_data);
      end else begin
         check(name, {24'b0, io_in_data}, {24'b0, rx_exp.pop_front()});
      end
      io_in_rdy = 1'b1;
      @(posedge clk);
      #1;
      io_in_rdy = 1'b0;
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stopb);
      logic [9:0] f;
      f = {stopb, b, 1'b0};
      for (int j = 0; j < 10; j++) begin
         uart_rx = f[j];
         tick(CPB);
      end
      uart_rx = 1'b1;
   endtask

   task automatic wait_tx_drain(input int limit);
      int g = 0;
      while (tx_exp.size() != 0 && g < limit) begin
         @(negedge clk);
         g++;
      end
      n_chk++;
      if (tx_exp.size() == 0) n_pass++;
      else $display("FAIL tx_drain: %0d bytes outstanding, expected 0", tx_exp.size());
   endtask

   initial begin
      logic [9:0] fr;
      vecs[0] = '{8'h3C, 1'b1, 1'b1, 5'b00000};
      vecs[1] = '{8'h00, 1'b1, 1'b1, 5'b00000};
      vecs[2] = '{8'hFF, 1'b1, 1'b1, 5'b00000};
      vecs[3] = '{8'h81, 1'b0, 1'b0, 5'b00010};
      vecs[4] = '{8'h5A, 1'b1, 1'b1, 5'b00010};

      // Reset values
      tick(3);
      @(negedge clk);
      check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
      check("rst_out_rdy", {31'b0, io_out_rdy}, 32'd1);
      check("rst_in_vld", {31'b0, io_in_vld}, 32'd0);
      check("rst_in_data", {24'b0, io_in_data}, 32'd0);
      check("rst_err", {27'b0, io_err}, 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      tick(3);

      // Single 0xA5 frame, exact cycle pattern
      cpu_write(8'hA5);
      fr = {1'b1, 8'hA5, 1'b0};
      @(negedge clk);
      check("t1_idle_before_start", {31'b0, uart_tx}, 32'd1);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check($sformatf("t1_bit_cycle%0d", i), {31'b0, uart_tx}, {31'b0, fr[i / 4]});
      end
      @(negedge clk);
      check("t1_idle_after", {31'b0, uart_tx}, 32'd1);
      tick(2);
      tx_start.delete();

      // Five bytes back to back with vld held
      for (int i = 1; i <= 5; i++) cpu_write(8'(i));
      @(negedge clk);
      check("t2_rdy_full", {31'b0, io_out_rdy}, 32'd0);
      repeat (36) @(negedge clk);
      check("t2_rdy_still_full", {31'b0, io_out_rdy}, 32'd0);
      @(negedge clk);
      check("t2_rdy_after_pop", {31'b0, io_out_rdy}, 32'd1);
      wait_tx_drain(300);
      if (tx_start.size() != 5) begin
         n_chk++;
         $display("FAIL t2_frame_count: got %0d frames, expected 5", tx_start.size());
      end else begin
         for (int i = 1; i < 5; i++)
            check($sformatf("t2_gap%0d", i), tx_start[i] - tx_start[i-1], 32'd40);
         check("t2_total_cycles", tx_start[4] - tx_start[0] + 40, 32'd200);
      end
      tick(4);

      // Single RX frame and one-cycle pop
      rx_exp.push_back(8'h3C);
      rx_frame(8'h3C, 1'b1);
      cpu_read("t3_rx_byte", 4);
      @(negedge clk);
      check("t3_vld_after_pop", {31'b0, io_in_vld}, 32'd0);
      tick(2);

      // Overflow: five frames with no pops
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) rx_exp.push_back(8'(i));
         rx_frame(8'(i), 1'b1);
      end
      tick(4);
      check("t4_err_ovf", {27'b0, io_err}, 32'd1);
      for (int i = 0; i < 4; i++) cpu_read($sformatf("t4_rx_order%0d", i), 8);
      @(negedge clk);
      check("t4_vld_empty", {31'b0, io_in_vld}, 32'd0);
      tick(2);

      // Framing error, then a one-cycle glitch
      rx_frame(8'h55, 1'b0);
      tick(4);
      check("t5_err_frame", {27'b0, io_err}, 32'd3);
      check("t5_no_push", {31'b0, io_in_vld}, 32'd0);
      uart_rx = 1'b0;
      tick(1);
      uart_rx = 1'b1;
      tick(12);
      check("t5_glitch_err", {27'b0, io_err}, 32'd3);
      check("t5_glitch_no_push", {31'b0, io_in_vld}, 32'd0);

      // Reset mid-TX and mid-RX frame with a byte sitting in the RX FIFO
      rx_frame(8'h77, 1'b1);
      tick(3);
      check("t6_rx_pending", {31'b0, io_in_vld}, 32'd1);
      cpu_write(8'h96);
      uart_rx = 1'b0;
      repeat (18) @(posedge clk);
      @(negedge clk);
      check("t6_tx_mid_frame", {31'b0, uart_tx}, 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      uart_rx = 1'b1;
      tx_exp.delete();
      rx_exp.delete();
      @(negedge clk);
      @(negedge clk);
      check("t6_uart_tx", {31'b0, uart_tx}, 32'd1);
      check("t6_out_rdy", {31'b0, io_out_rdy}, 32'd1);
      check("t6_in_vld", {31'b0, io_in_vld}, 32'd0);
      check("t6_in_data", {24'b0, io_in_data}, 32'd0);
      check("t6_err", {27'b0, io_err}, 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      tick(50);
      check("t6_tx_quiet", {31'b0, uart_tx}, 32'd1);
      check("t6_rx_quiet", {31'b0, io_in_vld}, 32'd0);

      // RX vector table
      for (int v = 0; v < 5; v++) begin
         if (vecs[v].exp_vld) rx_exp.push_back(vecs[v].data);
         rx_frame(vecs[v].data, vecs[v].stopb);
         tick(3);
         @(negedge clk);
         check($sformatf("vec%0d_vld", v), {31'b0, io_in_vld}, {31'b0, vecs[v].exp_vld});
         check($sformatf("vec%0d_err", v), {27'b0, io_err}, {27'b0, vecs[v].exp_err});
         if (vecs[v].exp_vld) cpu_read($sformatf("vec%0d_data", v), 4);
         tick(2);
      end

      // Extra TX patterns through the serial scoreboard
      cpu_write(8'h00);
      cpu_write(8'hFF);
      cpu_write(8'h5A);
      wait_tx_drain(300);
      tick(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
